// File: rtl/alu_seq_param_if.sv
// rtl/alu_seq_param_if.sv - operand/result handshake bundle for alu_seq_param
// Master is the producer of operands and consumer of results; slave is the ALU.
interface alu_seq_param_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_resultado;
  logic             zero;
  logic             carry_out;
  logic             overflow;
  logic             illegal_op;

  modport master (
    output in_valid, a, b, alu_control, out_ready,
    input  in_ready, out_valid, out_resultado, zero, carry_out, overflow, illegal_op
  );

  modport slave (
    input  in_valid, a, b, alu_control, out_ready,
    output in_ready, out_valid, out_resultado, zero, carry_out, overflow, illegal_op
  );
endinterface

// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - registered ALU with valid/ready handshake and iterative multiplier
// Single-cycle ops land in DONE one cycle after acceptance; MUL runs WIDTH shift-add steps first.
module alu_seq_param #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  alu_seq_param_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_ill;
  logic [WIDTH-1:0] mul_sum;

  assign in_ready = rst_n & ((state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;

  assign add_w = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_w = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
  assign sh    = bus.b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    unique case (bus.alu_control)
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (add_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (sub_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_SLL:  alu_res = bus.a << sh;
      OP_SRL:  alu_res = bus.a >> sh;
      OP_SRA:  alu_res = $unsigned($signed(bus.a) >>> sh);
      OP_MUL:  alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // One multiplier bit per step, LSB first; multiplicand shifts left to match its weight.
  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = S_DONE;
          res_d   = mul_sum;
          zero_d  = (mul_sum == '0);
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    // Acceptance overrides the DONE->IDLE step so back-to-back ops need no bubble.
    if (accept) begin
      if (bus.alu_control == OP_MUL) begin
        state_d  = S_MUL;
        mcand_d  = bus.a;
        mplier_d = bus.b;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        state_d = S_DONE;
        res_d   = alu_res;
        zero_d  = (alu_res == '0);
        carry_d = alu_c;
        ovf_d   = alu_v;
        ill_d   = alu_ill;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = (state_q == S_DONE);
  assign bus.out_resultado = res_q;
  assign bus.zero          = zero_q;
  assign bus.carry_out     = carry_q;
  assign bus.overflow      = ovf_q;
  assign bus.illegal_op    = ill_q;
endmodule
